// File: rtl/ctrl_defs.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package ctrl_defs;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ALU operation codes; these must stay in step with the ALU's own decode.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_LUI  = 4'd5;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    // Bit positions of the one-hot instruction class vector.
    localparam int unsigned CLS_W  = 11;
    localparam int unsigned C_ADDU = 0;
    localparam int unsigned C_SUBU = 1;
    localparam int unsigned C_ORI  = 2;
    localparam int unsigned C_LW   = 3;
    localparam int unsigned C_SW   = 4;
    localparam int unsigned C_BEQ  = 5;
    localparam int unsigned C_LUI  = 6;
    localparam int unsigned C_J    = 7;
    localparam int unsigned C_JAL  = 8;
    localparam int unsigned C_JR   = 9;
    localparam int unsigned C_NOP  = 10;

    // Instructions that complete in DECODE without using the ALU.
    function automatic logic ends_in_decode(input logic [CLS_W-1:0] cls);
        return cls[C_J] | cls[C_JAL] | cls[C_JR] | cls[C_NOP];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: op/funct to a one-hot class vector.
// Every encoding outside the supported subset maps to the nop class.
module ctrl_decode
    import ctrl_defs::*;
(
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls[C_ADDU] = 1'b1;
                    FN_SUBU: cls[C_SUBU] = 1'b1;
                    FN_JR:   cls[C_JR]   = 1'b1;
                    default: cls[C_NOP]  = 1'b1;
                endcase
            end
            OP_ORI:  cls[C_ORI] = 1'b1;
            OP_LW:   cls[C_LW]  = 1'b1;
            OP_SW:   cls[C_SW]  = 1'b1;
            OP_BEQ:  cls[C_BEQ] = 1'b1;
            OP_LUI:  cls[C_LUI] = 1'b1;
            OP_J:    cls[C_J]   = 1'b1;
            OP_JAL:  cls[C_JAL] = 1'b1;
            default: cls[C_NOP] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM with registered datapath controls and a
// retired-instruction counter.
module multi_cycle_ctrl
    import ctrl_defs::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             Branch,
    output logic [3:0]       ALUOP,
    output logic             ALUSrc,
    output logic             ExtOp,
    output logic             PCWr,
    output logic [1:0]       PCSrc,
    output logic             IRWr,
    output logic             RegWr,
    output logic [1:0]       RegDst,
    output logic [1:0]       WDSel,
    output logic             MemWr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic             live_q, live_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [3:0]       aluop_q, aluop_d;
    logic             alusrc_q, alusrc_d;
    logic             extop_q, extop_d;
    logic             pcwr_q, pcwr_d;
    logic [1:0]       pcsrc_q, pcsrc_d;
    logic             irwr_q, irwr_d;
    logic             regwr_q, regwr_d;
    logic [1:0]       regdst_q, regdst_d;
    logic [1:0]       wdsel_q, wdsel_d;
    logic             memwr_q, memwr_d;
    logic             beq_exec_q, beq_exec_d;
    logic [CLS_W-1:0] cls;

    // The decoder sees the instruction that will be held next cycle, so the
    // controls for the upcoming state can be registered one cycle early.
    assign op_d    = irwr_q ? op    : op_q;
    assign funct_d = irwr_q ? funct : funct_q;

    ctrl_decode u_decode (
        .op    (op_d),
        .funct (funct_d),
        .cls   (cls)
    );

    always_comb begin
        live_d  = 1'b1;
        state_d = S_FETCH;
        case (state_q)
            // The cycle right after reset release only arms the first fetch.
            S_FETCH:  state_d = live_q ? S_DECODE : S_FETCH;
            S_DECODE: state_d = ends_in_decode(cls) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (cls[C_LW] | cls[C_SW]) begin
                    state_d = S_MEM;
                end else if (cls[C_BEQ]) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM:    state_d = cls[C_LW] ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        aluop_d    = ALU_ADD;
        alusrc_d   = 1'b0;
        extop_d    = 1'b0;
        pcwr_d     = 1'b0;
        pcsrc_d    = PC_PLUS4;
        irwr_d     = 1'b0;
        regwr_d    = 1'b0;
        regdst_d   = RD_RT;
        wdsel_d    = WD_ALU;
        memwr_d    = 1'b0;
        beq_exec_d = 1'b0;
        case (state_d)
            S_FETCH: begin
                irwr_d  = 1'b1;
                pcwr_d  = 1'b1;
                pcsrc_d = PC_PLUS4;
            end
            S_DECODE: begin
                if (cls[C_J] | cls[C_JAL]) begin
                    pcwr_d  = 1'b1;
                    pcsrc_d = PC_JUMP;
                end
                if (cls[C_JAL]) begin
                    regwr_d  = 1'b1;
                    regdst_d = RD_RA;
                    wdsel_d  = WD_PC;
                end
                if (cls[C_JR]) begin
                    pcwr_d  = 1'b1;
                    pcsrc_d = PC_REG;
                end
            end
            S_EXEC: begin
                if (cls[C_SUBU]) begin
                    aluop_d = ALU_SUB;
                end
                if (cls[C_ORI]) begin
                    aluop_d  = ALU_OR;
                    alusrc_d = 1'b1;
                end
                if (cls[C_LUI]) begin
                    aluop_d  = ALU_LUI;
                    alusrc_d = 1'b1;
                end
                if (cls[C_LW] | cls[C_SW]) begin
                    alusrc_d = 1'b1;
                    extop_d  = 1'b1;
                end
                if (cls[C_BEQ]) begin
                    extop_d    = 1'b1;
                    pcsrc_d    = PC_BRANCH;
                    beq_exec_d = 1'b1;
                end
            end
            S_MEM: begin
                memwr_d = cls[C_SW];
            end
            S_WB: begin
                regwr_d  = 1'b1;
                regdst_d = (cls[C_ADDU] | cls[C_SUBU]) ? RD_RD : RD_RT;
                wdsel_d  = cls[C_LW] ? WD_DM : WD_ALU;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if ((state_d == S_FETCH) &&
            (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            live_q     <= 1'b0;
            op_q       <= '0;
            funct_q    <= '0;
            retired_q  <= '0;
            aluop_q    <= ALU_ADD;
            alusrc_q   <= 1'b0;
            extop_q    <= 1'b0;
            pcwr_q     <= 1'b0;
            pcsrc_q    <= PC_PLUS4;
            irwr_q     <= 1'b0;
            regwr_q    <= 1'b0;
            regdst_q   <= RD_RT;
            wdsel_q    <= WD_ALU;
            memwr_q    <= 1'b0;
            beq_exec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            op_q       <= op_d;
            funct_q    <= funct_d;
            retired_q  <= retired_d;
            aluop_q    <= aluop_d;
            alusrc_q   <= alusrc_d;
            extop_q    <= extop_d;
            pcwr_q     <= pcwr_d;
            pcsrc_q    <= pcsrc_d;
            irwr_q     <= irwr_d;
            regwr_q    <= regwr_d;
            regdst_q   <= regdst_d;
            wdsel_q    <= wdsel_d;
            memwr_q    <= memwr_d;
            beq_exec_q <= beq_exec_d;
        end
    end

    // A taken branch is only known during EXEC, so PCWr follows Branch live there.
    assign PCWr    = pcwr_q | (beq_exec_q & Branch);
    assign ALUOP   = aluop_q;
    assign ALUSrc  = alusrc_q;
    assign ExtOp   = extop_q;
    assign PCSrc   = pcsrc_q;
    assign IRWr    = irwr_q;
    assign RegWr   = regwr_q;
    assign RegDst  = regdst_q;
    assign WDSel   = wdsel_q;
    assign MemWr   = memwr_q;
    assign state   = state_q;
    assign retired = retired_q;

    // Register-file and memory writes never coincide; the IR only loads in FETCH.
    a_one_writer: assert property (@(posedge clk) disable iff (!reset) !(RegWr && MemWr));
    a_irwr_fetch: assert property (@(posedge clk) disable iff (!reset) IRWr |-> (state == S_FETCH));

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle sequences built from the
// instruction semantics, compared against two controller instances every cycle.
module tb_multi_cycle_ctrl;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_LUI = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10;

    typedef struct {
        logic [2:0] st;
        logic [3:0] aluop;
        logic       alusrc;
        logic       extop;
        logic       pcwr;
        logic       pcwr_br;
        logic [1:0] pcsrc;
        logic       irwr;
        logic       regwr;
        logic [1:0] regdst;
        logic [1:0] wdsel;
        logic       memwr;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [5:0]  op, funct;
    logic        Branch;

    logic [3:0]  ALUOP_a, ALUOP_b;
    logic        ALUSrc_a, ALUSrc_b, ExtOp_a, ExtOp_b, PCWr_a, PCWr_b;
    logic [1:0]  PCSrc_a, PCSrc_b;
    logic        IRWr_a, IRWr_b, RegWr_a, RegWr_b;
    logic [1:0]  RegDst_a, RegDst_b, WDSel_a, WDSel_b;
    logic        MemWr_a, MemWr_b;
    logic [2:0]  state_a, state_b;
    logic [31:0] retired_a;
    logic [2:0]  retired_b;

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .Branch(Branch),
        .ALUOP(ALUOP_a), .ALUSrc(ALUSrc_a), .ExtOp(ExtOp_a), .PCWr(PCWr_a),
        .PCSrc(PCSrc_a), .IRWr(IRWr_a), .RegWr(RegWr_a), .RegDst(RegDst_a),
        .WDSel(WDSel_a), .MemWr(MemWr_a), .state(state_a), .retired(retired_a)
    );

    // Narrow counter instance so wrap-around happens many times in one run.
    multi_cycle_ctrl #(.CNT_W(3)) dut_w3 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .Branch(Branch),
        .ALUOP(ALUOP_b), .ALUSrc(ALUSrc_b), .ExtOp(ExtOp_b), .PCWr(PCWr_b),
        .PCSrc(PCSrc_b), .IRWr(IRWr_b), .RegWr(RegWr_b), .RegDst(RegDst_b),
        .WDSel(WDSel_b), .MemWr(MemWr_b), .state(state_b), .retired(retired_b)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] completed = '0;
    rec_t        q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: begin
                if (f == 6'h21) return K_ADDU;
                if (f == 6'h23) return K_SUBU;
                if (f == 6'h08) return K_JR;
                return K_NOP;
            end
            6'h0d: return K_ORI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h0f: return K_LUI;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic rec_t blank(input logic [2:0] s);
        rec_t r;
        r.st = s; r.aluop = '0; r.alusrc = 1'b0; r.extop = 1'b0; r.pcwr = 1'b0;
        r.pcwr_br = 1'b0; r.pcsrc = '0; r.irwr = 1'b0; r.regwr = 1'b0;
        r.regdst = '0; r.wdsel = '0; r.memwr = 1'b0;
        return r;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, from FETCH to retirement.
    task automatic push_instr(input int k);
        rec_t r;
        r = blank(3'd0); r.irwr = 1'b1; r.pcwr = 1'b1; q.push_back(r);
        r = blank(3'd1);
        if (k == K_J || k == K_JAL) begin r.pcwr = 1'b1; r.pcsrc = 2'd2; end
        if (k == K_JAL) begin r.regwr = 1'b1; r.regdst = 2'd2; r.wdsel = 2'd2; end
        if (k == K_JR) begin r.pcwr = 1'b1; r.pcsrc = 2'd3; end
        q.push_back(r);
        if (k == K_J || k == K_JAL || k == K_JR || k == K_NOP) return;
        r = blank(3'd2);
        case (k)
            K_SUBU: r.aluop = 4'd1;
            K_ORI:  begin r.aluop = 4'd3; r.alusrc = 1'b1; end
            K_LUI:  begin r.aluop = 4'd5; r.alusrc = 1'b1; end
            K_LW, K_SW: begin r.alusrc = 1'b1; r.extop = 1'b1; end
            K_BEQ:  begin r.extop = 1'b1; r.pcsrc = 2'd1; r.pcwr_br = 1'b1; end
            default: ;
        endcase
        q.push_back(r);
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            r = blank(3'd3); r.memwr = (k == K_SW); q.push_back(r);
            if (k == K_SW) return;
        end
        r = blank(3'd4); r.regwr = 1'b1;
        r.regdst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        r.wdsel  = (k == K_LW) ? 2'd1 : 2'd0;
        q.push_back(r);
    endtask

    task automatic compare(input rec_t r);
        chk("state", 32'(state_a), 32'(r.st));
        chk("ALUOP", 32'(ALUOP_a), 32'(r.aluop));
        chk("ALUSrc", 32'(ALUSrc_a), 32'(r.alusrc));
        chk("ExtOp", 32'(ExtOp_a), 32'(r.extop));
        chk("PCWr", 32'(PCWr_a), 32'(r.pcwr_br ? Branch : r.pcwr));
        chk("PCSrc", 32'(PCSrc_a), 32'(r.pcsrc));
        chk("IRWr", 32'(IRWr_a), 32'(r.irwr));
        chk("RegWr", 32'(RegWr_a), 32'(r.regwr));
        chk("RegDst", 32'(RegDst_a), 32'(r.regdst));
        chk("WDSel", 32'(WDSel_a), 32'(r.wdsel));
        chk("MemWr", 32'(MemWr_a), 32'(r.memwr));
        chk("retired", retired_a, completed);
        chk("state_w3", 32'(state_b), 32'(r.st));
        chk("retired_w3", 32'(retired_b), completed % 8);
    endtask

    // Runs one instruction starting in its FETCH cycle; cut>0 stops early (for reset abort).
    // brm: 0/1 hold Branch at that value, 2 randomise it every cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int brm,
                             input int lat, input int cut);
        int n, meas;
        push_instr(kind_of(o, f));
        n = q.size();
        if (cut > 0) n = cut;
        meas = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) begin
                op = o; funct = f;
            end else begin
                op = 6'($urandom); funct = 6'($urandom);
            end
            Branch = (brm == 2) ? 1'($urandom) : (brm == 1);
            #1;
            if (c == 0 || state_a != 3'd0) meas++;
            compare(q.pop_front());
        end
        if (cut > 0) begin
            q.delete();
        end else begin
            completed = completed + 32'd1;
            if (lat > 0) chk("latency", 32'(meas), 32'(lat));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state_a), 32'd0);
        chk({tag, "_IRWr"}, 32'(IRWr_a), 32'd0);
        chk({tag, "_PCWr"}, 32'(PCWr_a), 32'd0);
        chk({tag, "_RegWr"}, 32'(RegWr_a), 32'd0);
        chk({tag, "_MemWr"}, 32'(MemWr_a), 32'd0);
        chk({tag, "_ALUOP"}, 32'(ALUOP_a), 32'd0);
        chk({tag, "_PCSrc"}, 32'(PCSrc_a), 32'd0);
        chk({tag, "_retired"}, retired_a, 32'd0);
        chk({tag, "_retired_w3"}, 32'(retired_b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    logic [5:0] d_op [14];
    logic [5:0] d_fn [14];
    int         d_br [14];
    int         d_lat[14];
    logic [5:0] r_op [10];
    logic [5:0] r_fn [10];

    initial begin
        d_op  = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h04, 6'h03, 6'h00, 6'h02, 6'h0d, 6'h0f, 6'h00, 6'h00, 6'h3f, 6'h00};
        d_fn  = '{6'h21, 6'h15, 6'h2a, 6'h00, 6'h00, 6'h11, 6'h08, 6'h21, 6'h08, 6'h23, 6'h23, 6'h00, 6'h00, 6'h3f};
        d_br  = '{2, 2, 2, 1, 0, 1, 1, 2, 2, 2, 2, 2, 2, 2};
        d_lat = '{4, 5, 4, 3, 3, 2, 2, 2, 4, 4, 4, 2, 2, 2};
        r_op  = '{6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h02, 6'h03, 6'h00};
        r_fn  = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

        reset = 1'b0; op = '0; funct = '0; Branch = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        // addu interrupted by reset during EXEC
        run_instr(6'h00, 6'h21, 1, 0, 3);
        reset = 1'b0;
        #1 check_reset_vals("abort");
        @(posedge clk);
        #1 check_reset_vals("held");
        @(negedge clk);
        reset = 1'b1;
        completed = '0;
        @(posedge clk);
        #1;
        chk("release_IRWr", 32'(IRWr_a), 32'd1);
        chk("release_state", 32'(state_a), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_instr(d_op[i], d_fn[i], d_br[i], d_lat[i], 0);
        end
        @(posedge clk);
        #1;
        chk("retired_directed", retired_a, 32'd14);
        chk("retired_directed_w3", 32'(retired_b), 32'd6);

        for (int i = 0; i < 1500; i++) begin
            int sel, idx;
            logic [5:0] o, f;
            sel = int'($urandom_range(0, 9));
            if (sel < 7) begin
                idx = int'($urandom_range(0, 9));
                o = r_op[idx];
                f = r_fn[idx];
            end else begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            run_instr(o, f, 2, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
